branch_tag_alloc: RTL and testbench
===================================

# branch_tag_alloc

Branch-tag allocator and recovery sequencer for the out-of-order core's branch-mask resource. It hands out one-hot branch tags to branches at dispatch, publishes the outstanding-branch mask that every dispatched micro-op carries, and frees tags when the branch execution unit resolves them. On a mispredict it computes the kill mask (the resolved tag plus every younger tag) and broadcasts it for one cycle. It sits between decode/dispatch and the branch execution unit.

## Interface
- WIDTH_BRM, 4, number of branch tags; width of every branch mask.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_alloc_req  in  1  dispatch requests a tag for one branch this cycle.
- o_alloc_ack  out  1  combinational; the request is granted this cycle.
- o_alloc_tag  out  WIDTH_BRM  combinational; one-hot granted tag, valid when o_alloc_ack=1, otherwise 0.
- o_full  out  1  registered; all tags outstanding.
- o_brmask  out  WIDTH_BRM  registered; set of outstanding tags, to attach to dispatched micro-ops.
- i_resolve_valid  in  1  branch unit resolves a branch this cycle.
- i_resolve_tag  in  WIDTH_BRM  one-hot tag being resolved.
- i_resolve_kill  in  1  resolution was a mispredict.
- o_kill_valid  out  1  registered one-cycle pulse: kill broadcast.
- o_kill_mask  out  WIDTH_BRM  registered; tags to squash, valid with o_kill_valid, else 0.

## Operation
- State: outstanding vector busy[WIDTH_BRM], dependency matrix dep[t][k] (=1: tag k is older than tag t), FSM {RUN, FLUSH}.
- Grant: o_alloc_ack = i_alloc_req & ~o_full & (state==RUN) & ~(i_resolve_valid & i_resolve_kill). o_alloc_tag = lowest-index zero bit of busy.
- On grant of tag t: busy[t]<=1; dep[t] <= busy (registered value, before this cycle's resolve).
- Correct resolve of tag k (busy[k]=1, kill=0): busy[k]<=0; dep[*][k]<=0.
- Kill resolve of tag k (busy[k]=1): K = {k} ∪ {j : dep[j][k]=1}; busy &= ~K; dep rows in K and columns in K cleared; o_kill_mask<=K; o_kill_valid<=1; state<=FLUSH.
- Resolve of a tag with busy=0, or a non-one-hot tag: ignored, no state change.
- FLUSH lasts exactly one cycle, then RUN. No grants in FLUSH. Resolves in FLUSH are processed normally; a kill resolve in FLUSH re-enters FLUSH with a new pulse.
- A tag freed this cycle is not grantable until the next cycle (grant uses registered busy).
- Same-cycle grant and correct resolve: both applied; the new tag's dep excludes nothing (uses pre-resolve busy), then column k is cleared the same edge.

## Timing
- Reset: busy=0, dep=0, state=RUN, o_brmask=0, o_full=0, o_kill_valid=0, o_kill_mask=0.
- Grant: 0-cycle combinational ack; o_brmask/o_full reflect it 1 cycle later.
- Resolve: o_brmask updates 1 cycle after i_resolve_valid.
- Kill: o_kill_valid/o_kill_mask pulse in the cycle after the kill resolve, coinciding with FLUSH; o_brmask excludes K in that same cycle.
- Reset mid-operation drops all tags and any pending kill pulse immediately (asynchronous).

## Test plan
- Reset, four consecutive requests -> tags 0001,0010,0100,1000; o_brmask 0001,0011,0111,1111 one cycle behind; o_full=1; fifth request ack=0, tag=0.
- From full, correct resolve 0010 -> o_brmask=1101, o_full=0 next cycle; request in that next cycle -> tag 0010; same-cycle request as resolve -> ack=0.
- Allocate 0001,0010,0100,1000 in order; kill resolve 0010 -> next cycle o_kill_valid=1, o_kill_mask=1110, o_brmask=0001; request during that cycle ack=0; following cycle request -> tag 0010.
- Request concurrent with kill resolve -> o_alloc_ack=0, no tag consumed; resolve of tag not outstanding (0100 when busy=0001) -> no change, no kill.
- Out-of-order allocation after frees (busy=0101, allocate 0010 as youngest); kill resolve 0001 -> o_kill_mask=0111.
- Assert i_rst_n=0 mid-sequence with busy=1011 and kill pulse pending -> all outputs 0 immediately; first post-reset grant is 0001.

Source files
------------

// File: rtl/branch_tag_alloc.sv
// Branch-tag allocator: hands out one-hot branch tags, tracks their age order,
// and broadcasts the squash set (resolved tag plus younger) on a mispredict.
module branch_tag_alloc #(
    parameter int WIDTH_BRM = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_ack,
    output logic [WIDTH_BRM-1:0] o_alloc_tag,
    output logic                 o_full,
    output logic [WIDTH_BRM-1:0] o_brmask,
    input  logic                 i_resolve_valid,
    input  logic [WIDTH_BRM-1:0] i_resolve_tag,
    input  logic                 i_resolve_kill,
    output logic                 o_kill_valid,
    output logic [WIDTH_BRM-1:0] o_kill_mask
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                              state_q, state_d;
    logic [WIDTH_BRM-1:0]                busy_q, busy_d;
    logic [WIDTH_BRM-1:0][WIDTH_BRM-1:0] dep_q, dep_d;
    logic                                kill_valid_q, kill_valid_d;
    logic [WIDTH_BRM-1:0]                kill_mask_q, kill_mask_d;

    logic [WIDTH_BRM-1:0] free_tag;
    logic [WIDTH_BRM-1:0] kill_set;
    logic                 full;
    logic                 resolve_hit;
    logic                 grant;

    assign full        = &busy_q;
    assign resolve_hit = i_resolve_valid & $onehot(i_resolve_tag) & (|(i_resolve_tag & busy_q));
    assign grant       = i_alloc_req & ~full & (state_q == RUN) & ~(i_resolve_valid & i_resolve_kill);

    // Lowest-index free tag; descending scan so the lowest index wins.
    always_comb begin
        free_tag = '0;
        for (int i = WIDTH_BRM - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_tag    = '0;
                free_tag[i] = 1'b1;
            end
        end
    end

    // Squash set: the resolved tag plus every tag whose row marks it as older.
    always_comb begin
        kill_set = i_resolve_tag;
        for (int j = 0; j < WIDTH_BRM; j++) begin
            if (|(dep_q[j] & i_resolve_tag)) begin
                kill_set[j] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d       = busy_q;
        dep_d        = dep_q;
        state_d      = RUN;
        kill_valid_d = 1'b0;
        kill_mask_d  = '0;

        if (grant) begin
            busy_d = busy_d | free_tag;
            for (int t = 0; t < WIDTH_BRM; t++) begin
                if (free_tag[t]) begin
                    dep_d[t] = busy_q;
                end
            end
        end

        // Column clearing runs after the grant so a same-edge grant row is scrubbed too.
        if (resolve_hit) begin
            if (i_resolve_kill) begin
                busy_d = busy_d & ~kill_set;
                for (int r = 0; r < WIDTH_BRM; r++) begin
                    if (kill_set[r]) begin
                        dep_d[r] = '0;
                    end
                    dep_d[r] = dep_d[r] & ~kill_set;
                end
                kill_valid_d = 1'b1;
                kill_mask_d  = kill_set;
                state_d      = FLUSH;
            end else begin
                busy_d = busy_d & ~i_resolve_tag;
                for (int r = 0; r < WIDTH_BRM; r++) begin
                    dep_d[r] = dep_d[r] & ~i_resolve_tag;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            busy_q       <= '0;
            dep_q        <= '0;
            kill_valid_q <= 1'b0;
            kill_mask_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            dep_q        <= dep_d;
            kill_valid_q <= kill_valid_d;
            kill_mask_q  <= kill_mask_d;
        end
    end

    assign o_alloc_ack  = grant;
    assign o_alloc_tag  = grant ? free_tag : '0;
    assign o_full       = full;
    assign o_brmask     = busy_q;
    assign o_kill_valid = kill_valid_q;
    assign o_kill_mask  = kill_mask_q;

endmodule

// File: tb/tb_branch_tag_alloc.sv
// Directed bench for branch_tag_alloc: allocation order, frees, kills,
// ignored resolves and asynchronous reset, with hand-computed expectations.
module tb_branch_tag_alloc;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_alloc_req;
    logic       o_alloc_ack;
    logic [3:0] o_alloc_tag;
    logic       o_full;
    logic [3:0] o_brmask;
    logic       i_resolve_valid;
    logic [3:0] i_resolve_tag;
    logic       i_resolve_kill;
    logic       o_kill_valid;
    logic [3:0] o_kill_mask;

    int checkCount = 0;
    int failCount  = 0;

    branch_tag_alloc #(.WIDTH_BRM(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_alloc_req    (i_alloc_req),
        .o_alloc_ack    (o_alloc_ack),
        .o_alloc_tag    (o_alloc_tag),
        .o_full         (o_full),
        .o_brmask       (o_brmask),
        .i_resolve_valid(i_resolve_valid),
        .i_resolve_tag  (i_resolve_tag),
        .i_resolve_kill (i_resolve_kill),
        .o_kill_valid   (o_kill_valid),
        .o_kill_mask    (o_kill_mask)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [3:0] observed, input logic [3:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", name, observed, expected);
        end
    endtask

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic req, input logic rv, input logic [3:0] tag, input logic kill);
        i_alloc_req     = req;
        i_resolve_valid = rv;
        i_resolve_tag   = tag;
        i_resolve_kill  = kill;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_alloc_req     = 1'b0;
        i_resolve_valid = 1'b0;
        i_resolve_tag   = 4'b0000;
        i_resolve_kill  = 1'b0;
    endtask

    task automatic checkRegs(input string name, input logic [3:0] mask, input logic full,
                             input logic kv, input logic [3:0] km);
        checkOutput({name, " brmask"}, o_brmask, mask);
        checkOutput({name, " full"}, 4'(o_full), 4'(full));
        checkOutput({name, " kill_valid"}, 4'(o_kill_valid), 4'(kv));
        checkOutput({name, " kill_mask"}, o_kill_mask, km);
    endtask

    task automatic allocExpect(input string name, input logic [3:0] expTag);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput({name, " ack"}, 4'(o_alloc_ack), 4'd1);
        checkOutput({name, " tag"}, o_alloc_tag, expTag);
        tick();
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        #3;
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        i_rst_n         = 1'b0;
        i_alloc_req     = 1'b0;
        i_resolve_valid = 1'b0;
        i_resolve_tag   = 4'b0000;
        i_resolve_kill  = 1'b0;
        #12;
        checkRegs("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
        i_rst_n = 1'b1;
        tick();

        // Four allocations in order, mask one cycle behind.
        allocExpect("alloc0", 4'b0001);
        checkOutput("mask after alloc0", o_brmask, 4'b0001);
        allocExpect("alloc1", 4'b0010);
        checkOutput("mask after alloc1", o_brmask, 4'b0011);
        allocExpect("alloc2", 4'b0100);
        checkOutput("mask after alloc2", o_brmask, 4'b0111);
        allocExpect("alloc3", 4'b1000);
        checkRegs("full", 4'b1111, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("fifth ack", 4'(o_alloc_ack), 4'd0);
        checkOutput("fifth tag", o_alloc_tag, 4'b0000);
        tick();

        // Correct resolve while full; freed tag not grantable the same cycle.
        applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0);
        checkOutput("req with resolve ack", 4'(o_alloc_ack), 4'd0);
        tick();
        checkRegs("after resolve 0010", 4'b1101, 1'b0, 1'b0, 4'b0000);
        allocExpect("realloc 0010", 4'b0010);
        checkOutput("mask refilled", o_brmask, 4'b1111);

        // Fresh ordered allocation, then kill the second-oldest.
        doReset();
        checkRegs("reset 2", 4'b0000, 1'b0, 1'b0, 4'b0000);
        allocExpect("k alloc0", 4'b0001);
        allocExpect("k alloc1", 4'b0010);
        allocExpect("k alloc2", 4'b0100);
        allocExpect("k alloc3", 4'b1000);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        tick();
        checkRegs("kill 0010", 4'b0001, 1'b0, 1'b1, 4'b1110);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("ack in flush", 4'(o_alloc_ack), 4'd0);
        checkOutput("tag in flush", o_alloc_tag, 4'b0000);
        tick();
        checkRegs("after flush", 4'b0001, 1'b0, 1'b0, 4'b0000);
        allocExpect("post flush alloc", 4'b0010);
        checkOutput("mask post flush", o_brmask, 4'b0011);

        // Request concurrent with kill is refused; stale resolves ignored.
        applyStimulus(1'b1, 1'b1, 4'b0010, 1'b1);
        checkOutput("req with kill ack", 4'(o_alloc_ack), 4'd0);
        checkOutput("req with kill tag", o_alloc_tag, 4'b0000);
        tick();
        checkRegs("kill youngest", 4'b0001, 1'b0, 1'b1, 4'b0010);
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1);
        tick();
        checkRegs("stale kill ignored", 4'b0001, 1'b0, 1'b0, 4'b0000);
        allocExpect("alloc after stale", 4'b0010);
        applyStimulus(1'b0, 1'b1, 4'b0011, 1'b1);
        tick();
        checkRegs("non-onehot ignored", 4'b0011, 1'b0, 1'b0, 4'b0000);

        // Out-of-order allocation: busy=0101, 0010 becomes youngest.
        allocExpect("ooo alloc 0100", 4'b0100);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
        tick();
        checkOutput("ooo mask 0101", o_brmask, 4'b0101);
        allocExpect("ooo alloc 0010", 4'b0010);
        checkOutput("ooo mask 0111", o_brmask, 4'b0111);
        applyStimulus(1'b0, 1'b1, 4'b0001, 1'b1);
        tick();
        checkRegs("ooo kill 0001", 4'b0000, 1'b0, 1'b1, 4'b0111);
        tick();

        // Same-cycle grant and correct resolve: new row loses the freed column.
        allocExpect("sc alloc 0001", 4'b0001);
        applyStimulus(1'b1, 1'b1, 4'b0001, 1'b0);
        checkOutput("sc ack", 4'(o_alloc_ack), 4'd1);
        checkOutput("sc tag", o_alloc_tag, 4'b0010);
        tick();
        checkOutput("sc mask", o_brmask, 4'b0010);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        tick();
        checkRegs("sc kill", 4'b0000, 1'b0, 1'b1, 4'b0010);
        tick();

        // Build busy=1011 with a kill pulse pending, then reset asynchronously.
        allocExpect("r alloc0", 4'b0001);
        allocExpect("r alloc1", 4'b0010);
        allocExpect("r alloc2", 4'b0100);
        allocExpect("r alloc3", 4'b1000);
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
        tick();
        allocExpect("r realloc 0100", 4'b0100);
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1);
        tick();
        checkRegs("pre-reset pulse", 4'b1011, 1'b0, 1'b1, 4'b0100);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkRegs("async reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("post-reset ack", 4'(o_alloc_ack), 4'd1);
        checkOutput("post-reset tag", o_alloc_tag, 4'b0001);
        tick();
        checkOutput("post-reset mask", o_brmask, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
